// File: rtl/ac_motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ac_motor_pkg
// Description : Shared constants for the AC-motor PWM modulator: carrier width
//               derivation, phase indices and direction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ac_motor_pkg;

    // Default carrier format (fractional bits + amplitude bits)
    localparam int c_BITS_DEFAULT       = 12;
    localparam int c_LEVEL_BITS_DEFAULT = 5;

    // Carrier / reference width is fractional plus amplitude bits, no guard bits
    function automatic int carrier_width(input int bits, input int level_bits);
        return bits + level_bits;
    endfunction

    // Phase indices into per-phase vectors
    localparam int c_PH_U   = 0;
    localparam int c_PH_V   = 1;
    localparam int c_PH_W   = 2;
    localparam int c_NUM_PH = 3;

    // Direction encoding as driven on dir_cw
    localparam logic c_DIR_CW  = 1'b1;
    localparam logic c_DIR_CCW = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ac_motor_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : ac_motor_deadtime
// Description : One inverter leg. Turns a demand bit into complementary
//               high/low gate drives separated by a dead-time gap.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_motor_deadtime
#(
    parameter int DEAD_CYCLES = 8
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic demand,
    output logic gate_h,
    output logic gate_l
);

    localparam int                 c_CNT_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DEAD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_dem_prev;
    logic               r_en_prev;
    logic               r_gate_h;
    logic               r_gate_l;
    logic               w_gate_h_nxt;
    logic               w_gate_l_nxt;
    logic               w_restart;

    // Counter and gate selection: any demand edge, or the first enabled cycle,
    // reloads the gap; a side is only driven once the gap has fully elapsed.
    always_comb begin
        w_restart    = (demand != r_dem_prev) || !r_en_prev;
        w_cnt_nxt    = r_cnt;
        w_gate_h_nxt = 1'b0;
        w_gate_l_nxt = 1'b0;
        if (!enable || w_restart) begin
            w_cnt_nxt = c_CNT_LOAD;
        end else begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
            if (w_cnt_nxt == '0) begin
                w_gate_h_nxt = demand;
                w_gate_l_nxt = !demand;
            end
        end
    end

    // State and registered gate outputs; reset drops both gates immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= c_CNT_LOAD;
            r_dem_prev <= 1'b0;
            r_en_prev  <= 1'b0;
            r_gate_h   <= 1'b0;
            r_gate_l   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_dem_prev <= demand;
            r_en_prev  <= enable;
            r_gate_h   <= w_gate_h_nxt;
            r_gate_l   <= w_gate_l_nxt;
        end
    end

    assign gate_h = r_gate_h;
    assign gate_l = r_gate_l;

endmodule
`default_nettype wire

// File: rtl/ac_motor_pwm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : ac_motor_pwm_modulator
// Description : Compares three shadowed phase references against the signed
//               triangle carrier and drives six dead-timed gate outputs.
//               Handles slope/peak/valley tracking, reference shadowing and
//               CW/CCW phase mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_motor_pwm_modulator
    import ac_motor_pkg::*;
#(
    parameter int BITS        = c_BITS_DEFAULT,
    parameter int LEVEL_BITS  = c_LEVEL_BITS_DEFAULT,
    parameter int DEAD_CYCLES = 8,
    parameter int UPDATE_BOTH = 1
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [BITS+LEVEL_BITS-1:0]   triangle,
    input  logic                         cw_in,
    input  logic                         ccw_in,
    input  logic [BITS+LEVEL_BITS-1:0]   ref_u,
    input  logic [BITS+LEVEL_BITS-1:0]   ref_v,
    input  logic [BITS+LEVEL_BITS-1:0]   ref_w,
    output logic                         gate_uh,
    output logic                         gate_ul,
    output logic                         gate_vh,
    output logic                         gate_vl,
    output logic                         gate_wh,
    output logic                         gate_wl,
    output logic                         sync,
    output logic                         dir_cw
);

    localparam int c_W = carrier_width(BITS, LEVEL_BITS);

    logic [c_W-1:0]      r_tri_q;
    logic [c_W-1:0]      r_tri_q2;
    logic [c_W-1:0]      r_ref_u;
    logic [c_W-1:0]      r_ref_v;
    logic [c_W-1:0]      r_ref_w;
    logic                r_slope_rise;
    logic                r_slope_prev;
    logic                r_sync;
    logic                r_dir_cw;
    logic [c_NUM_PH-1:0] r_demand;

    logic                w_slope_rise_nxt;
    logic                w_valley;
    logic                w_peak;
    logic                w_load;
    logic                w_dir_nxt;
    logic [c_W-1:0]      w_ph_ref [c_NUM_PH];
    logic [c_NUM_PH-1:0] w_demand_nxt;
    logic [c_NUM_PH-1:0] w_gate_h;
    logic [c_NUM_PH-1:0] w_gate_l;

    // Slope tracking, turning-point detection and direction selection
    always_comb begin
        if ($signed(r_tri_q) > $signed(r_tri_q2)) begin
            w_slope_rise_nxt = 1'b1;
        end else if ($signed(r_tri_q) < $signed(r_tri_q2)) begin
            w_slope_rise_nxt = 1'b0;
        end else begin
            w_slope_rise_nxt = r_slope_rise;
        end
        w_valley  = r_slope_rise && !r_slope_prev;
        w_peak    = !r_slope_rise && r_slope_prev;
        w_load    = w_valley || ((UPDATE_BOTH != 0) && w_peak);
        w_dir_nxt = r_dir_cw;
        if (w_valley) begin
            if (cw_in && !ccw_in) begin
                w_dir_nxt = c_DIR_CW;
            end else if (ccw_in && !cw_in) begin
                w_dir_nxt = c_DIR_CCW;
            end
        end
    end

    // Phase map (CCW swaps V and W sources) and signed carrier comparison
    always_comb begin
        w_ph_ref[c_PH_U] = r_ref_u;
        w_ph_ref[c_PH_V] = (r_dir_cw == c_DIR_CW) ? r_ref_v : r_ref_w;
        w_ph_ref[c_PH_W] = (r_dir_cw == c_DIR_CW) ? r_ref_w : r_ref_v;
        for (int p = 0; p < c_NUM_PH; p++) begin
            w_demand_nxt[p] = $signed(w_ph_ref[p]) > $signed(r_tri_q);
        end
    end

    // Carrier pipeline, shadow references, direction latch and demand bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tri_q      <= '0;
            r_tri_q2     <= '0;
            r_ref_u      <= '0;
            r_ref_v      <= '0;
            r_ref_w      <= '0;
            r_slope_rise <= 1'b1;
            r_slope_prev <= 1'b1;
            r_sync       <= 1'b0;
            r_dir_cw     <= c_DIR_CW;
            r_demand     <= '0;
        end else begin
            r_tri_q      <= triangle;
            r_tri_q2     <= r_tri_q;
            r_slope_rise <= w_slope_rise_nxt;
            r_slope_prev <= r_slope_rise;
            r_sync       <= w_valley;
            r_dir_cw     <= w_dir_nxt;
            r_demand     <= w_demand_nxt;
            if (w_load) begin
                r_ref_u <= ref_u;
                r_ref_v <= ref_v;
                r_ref_w <= ref_w;
            end
        end
    end

    for (genvar gi = 0; gi < c_NUM_PH; gi++) begin : g_phase
        ac_motor_deadtime #(
            .DEAD_CYCLES (DEAD_CYCLES)
        ) u_deadtime (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .demand (r_demand[gi]),
            .gate_h (w_gate_h[gi]),
            .gate_l (w_gate_l[gi])
        );
    end

    assign gate_uh = w_gate_h[c_PH_U];
    assign gate_ul = w_gate_l[c_PH_U];
    assign gate_vh = w_gate_h[c_PH_V];
    assign gate_vl = w_gate_l[c_PH_V];
    assign gate_wh = w_gate_h[c_PH_W];
    assign gate_wl = w_gate_l[c_PH_W];
    assign sync    = r_sync;
    assign dir_cw  = r_dir_cw;

endmodule
`default_nettype wire
